// File: rtl/shift_reg_reader_if.sv
// Handshake and bus bundle between the tap reader, the shift register it
// addresses and the downstream sample consumer.
interface shift_reg_reader_if #(
  parameter int dataWidth = 16
);
  logic                 start;
  logic [5:0]           address;
  logic [dataWidth-1:0] reg_dout;
  logic [dataWidth-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ready;
  logic                 last;
  logic                 busy;
  logic                 done;

  // Reader side: drives the tap address and the output sample stream.
  modport master (
    input  start, reg_dout, dout_ready,
    output address, dout, dout_valid, last, busy, done
  );

  // Environment side: shift register, sweep requester and consumer.
  modport slave (
    output start, reg_dout, dout_ready,
    input  address, dout, dout_valid, last, busy, done
  );
endinterface

// File: rtl/shift_reg_reader.sv
// Sweeps tap addresses 0..taps-1 of an external shift register once per
// start request and streams the read samples out over a valid/ready
// handshake, flagging the final sample and pulsing done when it is taken.
module shift_reg_reader #(
  parameter int dataWidth = 16,
  parameter int taps      = 64
) (
  input  logic               clk,
  input  logic               rst,
  shift_reg_reader_if.master bus
);

  localparam logic [5:0] LastAddr = 6'(taps - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t               state;
  logic [5:0]           address;
  logic [dataWidth-1:0] dout;
  logic                 dout_valid;
  logic                 last;
  logic                 busy;
  logic                 done;
  logic                 load;

  // A new sample may be captured when the output slot is empty or is being
  // emptied this very cycle, which gives one sample per cycle without bubbles.
  assign load = (state == READ) && (!dout_valid || bus.dout_ready);

  // Sweep controller: all outputs are registered and change only on clk.
  always_ff @(posedge clk) begin
    // NOTE: every register here is a small flop with a defined reset value;
    // nonblocking assignments keep each branch reading pre-edge values.
    if (!rst) begin
      state      <= IDLE;
      address    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          address <= '0;
          if (bus.start) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (load) begin
            dout       <= bus.reg_dout;
            dout_valid <= 1'b1;
            last       <= (address == LastAddr);
            // The counter parks on the final tap instead of wrapping.
            if (address == LastAddr) state <= DRAIN;
            else                     address <= address + 6'd1;
          end
        end
        DRAIN: begin
          if (dout_valid && bus.dout_ready) begin
            dout_valid <= 1'b0;
            last       <= 1'b0;
            address    <= '0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.address    = address;
  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.last       = last;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_shift_reg_reader.sv
// Scoreboard bench: each accepted sweep pushes its expected samples, a
// negedge monitor compares whatever the reader presents against the queue.
module tb_shift_reg_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_reg_reader_if #(.dataWidth(16)) ifa ();
  shift_reg_reader_if #(.dataWidth(16)) ifb ();

  // Shift register model: tap k holds k*3.
  assign ifa.reg_dout = 16'(ifa.address * 3);
  assign ifb.reg_dout = 16'(ifb.address * 3);

  shift_reg_reader #(.dataWidth(16), .taps(64)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  shift_reg_reader #(.dataWidth(16), .taps(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic [15:0] data;
    logic        last;
  } sample_t;

  sample_t exp_q[$];
  int      tests = 0;
  int      fails = 0;
  int      xfer_count = 0;
  int      done_count = 0;
  logic    pending_done = 1'b0;
  bit      rand_ready = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One full sweep from the reference rule: taps samples, tap k reads k*3.
  task automatic push_sweep(int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{16'(k * 3), (k == n - 1)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) ifa.dout_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start_a();
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!ifa.done && cycles < 2000) begin
      tick();
      cycles++;
    end
    if (!ifa.done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_xfers(int base, int n);
    int budget = 0;
    while ((xfer_count - base) < n && budget < 2000) begin
      tick();
      budget++;
    end
    if ((xfer_count - base) < n) check("xfer_timeout", xfer_count - base, n);
  endtask

  // Monitor for the 64-tap instance: presented samples must match the queue
  // head, and done must follow exactly one cycle after the final transfer.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      pending_done = 1'b0;
    end else begin
      check("done_pulse", ifa.done, pending_done);
      if (ifa.done) done_count++;
      pending_done = 1'b0;
      if (ifa.dout_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_sample", 1, 0);
        end else begin
          check("dout", ifa.dout, exp_q[0].data);
          check("last", ifa.last, exp_q[0].last);
          if (ifa.dout_ready) begin
            pending_done = exp_q[0].last;
            void'(exp_q.pop_front());
            xfer_count++;
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int d0;
    int x0;

    rst = 1'b0;
    ifa.start = 1'b0;
    ifa.dout_ready = 1'b0;
    ifb.start = 1'b0;
    ifb.dout_ready = 1'b0;

    // Reset held for two edges.
    repeat (2) tick();
    check("rst_valid", ifa.dout_valid, 0);
    check("rst_dout", ifa.dout, 0);
    check("rst_last", ifa.last, 0);
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_addr", ifa.address, 0);
    check("rst_b_valid", ifb.dout_valid, 0);
    rst = 1'b1;

    // Full sweep with the consumer always ready.
    ifa.dout_ready = 1'b1;
    push_sweep(64);
    d0 = done_count;
    pulse_start_a();
    check("busy_after_start", ifa.busy, 1);
    check("no_valid_on_entry", ifa.dout_valid, 0);
    tick();
    check("first_valid", ifa.dout_valid, 1);
    wait_done(cyc);
    check("sweep_cycles", cyc, 64);
    tick();
    check("busy_after_done", ifa.busy, 0);
    check("done_one_cycle", ifa.done, 0);
    check("done_count_1", done_count - d0, 1);
    check("queue_empty_1", exp_q.size(), 0);

    // Backpressure on the third sample.
    push_sweep(64);
    pulse_start_a();
    repeat (3) tick();
    check("third_sample", ifa.dout, 6);
    ifa.dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_dout", ifa.dout, 6);
      check("stall_addr", ifa.address, 3);
      check("stall_valid", ifa.dout_valid, 1);
    end
    ifa.dout_ready = 1'b1;
    rand_ready = 1'b1;
    wait_done(cyc);
    tick();
    check("queue_empty_2", exp_q.size(), 0);
    check("busy_after_2", ifa.busy, 0);

    // Extra start mid-sweep and during FIN must be ignored.
    push_sweep(64);
    d0 = done_count;
    x0 = xfer_count;
    pulse_start_a();
    wait_xfers(x0, 10);
    pulse_start_a();
    wait_done(cyc);
    pulse_start_a();
    repeat (10) tick();
    check("ignored_busy", ifa.busy, 0);
    check("ignored_valid", ifa.dout_valid, 0);
    check("ignored_done_count", done_count - d0, 1);
    check("ignored_xfers", xfer_count - x0, 64);
    check("queue_empty_3", exp_q.size(), 0);

    // Reset after 20 samples aborts the sweep.
    rand_ready = 1'b0;
    ifa.dout_ready = 1'b1;
    push_sweep(64);
    pulse_start_a();
    wait_xfers(xfer_count, 20);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("abort_valid", ifa.dout_valid, 0);
    check("abort_busy", ifa.busy, 0);
    check("abort_addr", ifa.address, 0);
    check("abort_flushed", exp_q.size(), 0);
    d0 = done_count;
    repeat (80) tick();
    check("abort_no_done", done_count - d0, 0);
    check("abort_idle_valid", ifa.dout_valid, 0);

    // Fresh sweep after the abort restarts at tap 0.
    push_sweep(64);
    d0 = done_count;
    pulse_start_a();
    tick();
    check("restart_dout", ifa.dout, 0);
    check("restart_valid", ifa.dout_valid, 1);
    wait_done(cyc);
    tick();
    check("restart_done_count", done_count - d0, 1);
    check("queue_empty_4", exp_q.size(), 0);

    // Two-tap instance with the consumer toggling ready 1,0,1.
    ifb.dout_ready = 1'b1;
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    tick();
    check("b_s0_valid", ifb.dout_valid, 1);
    check("b_s0_dout", ifb.dout, 0);
    check("b_s0_last", ifb.last, 0);
    tick();
    check("b_s1_dout", ifb.dout, 3);
    check("b_s1_last", ifb.last, 1);
    ifb.dout_ready = 1'b0;
    tick();
    check("b_hold_dout", ifb.dout, 3);
    check("b_hold_last", ifb.last, 1);
    check("b_hold_valid", ifb.dout_valid, 1);
    check("b_hold_addr", ifb.address, 1);
    check("b_hold_busy", ifb.busy, 1);
    check("b_hold_done", ifb.done, 0);
    ifb.dout_ready = 1'b1;
    tick();
    check("b_done", ifb.done, 1);
    check("b_valid_after", ifb.dout_valid, 0);
    check("b_busy_fin", ifb.busy, 0);
    check("b_addr_fin", ifb.address, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_done_once", ifb.done, 0);
      check("b_no_more", ifb.dout_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_reader.md
SHIFT_REG_READER -- requirements
Module: shift_reg_reader

Interface
REQ-001 The block SHALL have parameter dataWidth, default 16, giving the sample width in bits.
REQ-002 The block SHALL have parameter taps, default 64 (range 2..64), giving the number of shift-register entries read per sweep.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  is the reset: synchronous, active-low; asserted when 0 at a rising clk edge.
REQ-005 Port start  input  1  requests one read sweep; sampled only in IDLE.
REQ-006 Port address  output  6  is the tap address driven to the shift register.
REQ-007 Port reg_dout  input  dataWidth  is the shift-register read data, a combinational function of address.
REQ-008 Port dout  output  dataWidth  is the registered output sample.
REQ-009 Port dout_valid  output  1  indicates dout holds an unconsumed sample.
REQ-010 Port dout_ready  input  1  indicates the consumer accepts dout this cycle.
REQ-011 Port last  output  1  marks the sample read from address taps-1; valid only with dout_valid.
REQ-012 Port busy  output  1  is high from the cycle after start is accepted until done.
REQ-013 Port done  output  1  is a one-cycle pulse after the last sample is accepted.

Function
REQ-014 The FSM SHALL have states IDLE, READ, DRAIN and FIN.
REQ-015 IDLE: address=0, busy=0; start=1 at an edge -> READ.
REQ-016 Load condition: load = (state==READ) && (!dout_valid || dout_ready).
REQ-017 On load: dout<=reg_dout, dout_valid<=1, last<=(address==taps-1), and address<=address+1 if address<taps-1.
REQ-018 On load with address==taps-1: next state DRAIN; address holds at taps-1.
REQ-019 Without load in READ (stall): address, dout, dout_valid and last hold unchanged.
REQ-020 Handshake: a sample transfers on any edge with dout_valid && dout_ready; without a new load, dout_valid<=0 and last<=0.
REQ-021 dout and last SHALL NOT change while dout_valid=1 and dout_ready=0.
REQ-022 Back-to-back: with dout_ready held at 1, one sample transfers per cycle; the first dout_valid rises one cycle after entering READ.
REQ-023 DRAIN: when the last sample transfers -> FIN; address<=0.
REQ-024 FIN: done=1 for exactly one cycle, then -> IDLE; busy=1 in READ and DRAIN, 0 in FIN and IDLE.
REQ-025 start while busy or in FIN SHALL be ignored (not queued).
REQ-026 Each sweep SHALL emit exactly taps samples, in order of addresses 0..taps-1, with last set only on the final one.
REQ-027 The address counter SHALL never exceed taps-1 and SHALL never wrap within a sweep.

Reset
REQ-028 While rst=0 at an edge: state<=IDLE, address<=0, dout<=0, dout_valid<=0, last<=0, busy<=0, done<=0.
REQ-029 Reset mid-sweep SHALL abort the sweep with no further samples or done pulse; the next start begins again at address 0.
REQ-030 rst SHALL take priority over start and over the handshake in the same cycle.

Verification
REQ-031 Reset: rst=0 for 2 cycles -> all outputs 0, address=0, no done pulse.
REQ-032 taps=64, reg_dout=address*3, dout_ready=1, one start pulse -> 64 samples 0,3,...,189 on consecutive cycles; last only on 189; done one cycle after it; busy 0 afterward.
REQ-033 Backpressure: dout_ready=0 for 5 cycles on the 3rd sample -> dout holds 6; address holds at 3; sequence resumes without loss or duplication.
REQ-034 start pulsed again at sample 10 and during FIN -> ignored; exactly 64 samples and one done.
REQ-035 rst=0 after 20 samples -> dout_valid=0 next edge; no done; a fresh start emits from address 0.
REQ-036 taps=2, dout_ready toggling 1,0,1 -> samples from addresses 0 and 1 only; last on the second; done once.
